sr_flag_bank: RTL and testbench

- Clocked, multi-channel successor to the free-running NAND SR latch.
- Provides CHANNELS independent set/reset flags with input synchronisers and optional edge qualification.
- Resolves the S&R-both-active case deterministically by parameter instead of leaving it illegal, and flags that case in a sticky per-channel status bit.
- Sits between async/pad-side event sources (UART line events, button strobes) and the synchronous control logic.

---
 rtl/sr_flag_bank_pkg.sv | 24 ++
 rtl/sr_flag_cell.sv | 58 +++++
 rtl/sync_ff_chain.sv | 33 +++
 rtl/sr_flag_bank.sv | 75 +++++++
 tb/tb_sr_flag_bank.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/sr_flag_bank_pkg.sv
// Shared definitions for the sr_flag_bank flag array: conflict resolution
// encodings, the default synchroniser depth and the conflict resolver.
package sr_flag_bank_pkg;

  typedef enum logic [1:0] {
    CM_RESET_DOM = 2'd0,
    CM_SET_DOM   = 2'd1,
    CM_HOLD      = 2'd2,
    CM_TOGGLE    = 2'd3
  } conflict_mode_e;

  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

  // Next flag value when set and reset are qualified in the same cycle.
  function automatic logic resolve_conflict(input conflict_mode_e mode, input logic q);
    case (mode)
      CM_RESET_DOM: return 1'b0;
      CM_SET_DOM:   return 1'b1;
      CM_HOLD:      return q;
      default:      return ~q;
    endcase
  endfunction

endpackage

// File: rtl/sr_flag_cell.sv
// One flag channel: level/edge qualification of already-synchronised,
// active-high set/reset requests, conflict resolution, sticky conflict and rise pulse.
module sr_flag_cell
  import sr_flag_bank_pkg::*;
#(
  parameter bit             EDGE          = 1'b0,
  parameter conflict_mode_e CONFLICT_MODE = CM_RESET_DOM,
  parameter bit             INIT          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic rst_req,
  input  logic conflict_clr,
  output logic q,
  output logic q_rise,
  output logic conflict
);

  logic prev_s;
  logic prev_r;
  logic q_d;
  logic act_s;
  logic act_r;
  logic q_next;

  always_comb begin
    act_s  = EDGE ? (set_req & ~prev_s) : set_req;
    act_r  = EDGE ? (rst_req & ~prev_r) : rst_req;
    q_next = q;
    case ({act_s, act_r})
      2'b10:   q_next = 1'b1;
      2'b01:   q_next = 1'b0;
      2'b11:   q_next = resolve_conflict(CONFLICT_MODE, q);
      default: q_next = q;
    endcase
  end

  // q_d starts at INIT so that reset release can never look like a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= INIT;
      q_d      <= INIT;
      q_rise   <= 1'b0;
      conflict <= 1'b0;
      prev_s   <= 1'b0;
      prev_r   <= 1'b0;
    end else begin
      q        <= q_next;
      q_d      <= q;
      q_rise   <= q & ~q_d;
      conflict <= (act_s & act_r) | (conflict & ~conflict_clr);
      prev_s   <= set_req;
      prev_r   <= rst_req;
    end
  end

endmodule

// File: rtl/sync_ff_chain.sv
// Multi-bit flop chain used as an input synchroniser; zero stages is a
// straight pass-through for inputs that are already synchronous.
module sync_ff_chain #(
  parameter int unsigned     WIDTH       = 1,
  parameter int unsigned     STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q = d;
  end else begin : g_chain
    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < STAGES; i++) stage[i] <= RESET_VALUE;
      end else begin
        stage[0] <= d;
        for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[STAGES-1];
  end

endmodule

// File: rtl/sr_flag_bank.sv
// Clocked multi-channel set/reset flag bank with input synchronisers,
// optional edge qualification and deterministic S&R conflict resolution.
module sr_flag_bank
  import sr_flag_bank_pkg::*;
#(
  parameter int unsigned          CHANNELS         = 8,
  parameter int unsigned          SYNC_STAGES      = DEFAULT_SYNC_STAGES,
  parameter bit                   INPUT_ACTIVE_LOW = 1'b1,
  parameter logic [CHANNELS-1:0]  EDGE_MASK        = '0,
  parameter int unsigned          CONFLICT_MODE    = 0,
  parameter logic [CHANNELS-1:0]  INIT_VALUE       = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] s,
  input  logic [CHANNELS-1:0] r,
  input  logic [CHANNELS-1:0] conflict_clr,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] qn,
  output logic [CHANNELS-1:0] q_rise,
  output logic [CHANNELS-1:0] conflict
);

  logic [CHANNELS-1:0] a_s;
  logic [CHANNELS-1:0] a_r;
  logic [CHANNELS-1:0] sync_s;
  logic [CHANNELS-1:0] sync_r;

  // Normalise to active-high before synchronising so the sync reset value is
  // the inactive level regardless of pad polarity.
  assign a_s = s ^ {CHANNELS{INPUT_ACTIVE_LOW}};
  assign a_r = r ^ {CHANNELS{INPUT_ACTIVE_LOW}};

  sync_ff_chain #(
    .WIDTH       (CHANNELS),
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE ('0)
  ) u_sync_s (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (a_s),
    .q     (sync_s)
  );

  sync_ff_chain #(
    .WIDTH       (CHANNELS),
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE ('0)
  ) u_sync_r (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (a_r),
    .q     (sync_r)
  );

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
    sr_flag_cell #(
      .EDGE          (EDGE_MASK[i]),
      .CONFLICT_MODE (conflict_mode_e'(CONFLICT_MODE)),
      .INIT          (INIT_VALUE[i])
    ) u_cell (
      .clk          (clk),
      .rst_n        (rst_n),
      .set_req      (sync_s[i]),
      .rst_req      (sync_r[i]),
      .conflict_clr (conflict_clr[i]),
      .q            (q[i]),
      .q_rise       (q_rise[i]),
      .conflict     (conflict[i])
    );
  end

  assign qn = ~q;

endmodule

// File: tb/tb_sr_flag_bank.sv
// Directed bench for sr_flag_bank: four instances, one per conflict mode,
// sharing stimulus; INIT_VALUE=8'hA5, channel 2 edge-qualified.
module tb_sr_flag_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s;
  logic [7:0] r;
  logic [7:0] clr;
  logic [7:0] q_a    [4];
  logic [7:0] qn_a   [4];
  logic [7:0] rise_a [4];
  logic [7:0] conf_a [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    sr_flag_bank #(
      .CHANNELS         (8),
      .SYNC_STAGES      (2),
      .INPUT_ACTIVE_LOW (1'b1),
      .EDGE_MASK        (8'h04),
      .CONFLICT_MODE    (m),
      .INIT_VALUE       (8'hA5)
    ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s            (s),
      .r            (r),
      .conflict_clr (clr),
      .q            (q_a[m]),
      .qn           (qn_a[m]),
      .q_rise       (rise_a[m]),
      .conflict     (conf_a[m])
    );
  end

  typedef struct packed {
    logic [7:0]      s;
    logic [7:0]      r;
    logic [7:0]      clr;
    logic [3:0][7:0] q;
    logic [7:0]      rise;
    logic [7:0]      rise3;
    logic [7:0]      conf;
  } vec_t;

  function automatic vec_t v(input logic [7:0] sv, rv, cv, q0, q1, q2, q3,
                             input logic [7:0] rs, rs3, cf);
    vec_t t;
    t.s = sv; t.r = rv; t.clr = cv;
    t.q[0] = q0; t.q[1] = q1; t.q[2] = q2; t.q[3] = q3;
    t.rise = rs; t.rise3 = rs3; t.conf = cf;
    return t;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [7:0] sv, input logic [7:0] rv, input logic [7:0] cv);
    s = sv; r = rv; clr = cv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_q(input string name, input logic [7:0] exp);
    for (int m = 0; m < 4; m++) begin
      check(name, q_a[m], exp);
      check({name, "_qn"}, qn_a[m], ~exp);
    end
  endtask

  vec_t tbl [22];

  initial begin
    tbl[0]  = v(8'hFF, 8'hFE, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00);
    tbl[1]  = v(8'hFF, 8'hFF, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00);
    tbl[2]  = v(8'hFF, 8'hFF, 8'h00, 8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'h00, 8'h00, 8'h00);
    tbl[3]  = v(8'hFE, 8'hFF, 8'h00, 8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'h00, 8'h00, 8'h00);
    tbl[4]  = v(8'hFF, 8'hFF, 8'h00, 8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'h00, 8'h00, 8'h00);
    tbl[5]  = v(8'hFF, 8'hFF, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00);
    tbl[6]  = v(8'hFF, 8'hFF, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h01, 8'h00);
    tbl[7]  = v(8'hFF, 8'hFF, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00);
    tbl[8]  = v(8'hFD, 8'hFF, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00);
    tbl[9]  = v(8'hFF, 8'hFF, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00);
    tbl[10] = v(8'hFF, 8'hFF, 8'h00, 8'hA7, 8'hA7, 8'hA7, 8'hA7, 8'h00, 8'h00, 8'h00);
    tbl[11] = v(8'hFF, 8'hFF, 8'h00, 8'hA7, 8'hA7, 8'hA7, 8'hA7, 8'h02, 8'h02, 8'h00);
    tbl[12] = v(8'hFD, 8'hFD, 8'h00, 8'hA7, 8'hA7, 8'hA7, 8'hA7, 8'h00, 8'h00, 8'h00);
    tbl[13] = v(8'hFF, 8'hFF, 8'h00, 8'hA7, 8'hA7, 8'hA7, 8'hA7, 8'h00, 8'h00, 8'h00);
    tbl[14] = v(8'hFF, 8'hFF, 8'h00, 8'hA5, 8'hA7, 8'hA7, 8'hA5, 8'h00, 8'h00, 8'h02);
    tbl[15] = v(8'hFF, 8'hFF, 8'h00, 8'hA5, 8'hA7, 8'hA7, 8'hA5, 8'h00, 8'h00, 8'h02);
    tbl[16] = v(8'hFF, 8'hFF, 8'h02, 8'hA5, 8'hA7, 8'hA7, 8'hA5, 8'h00, 8'h00, 8'h00);
    tbl[17] = v(8'hFD, 8'hFD, 8'h00, 8'hA5, 8'hA7, 8'hA7, 8'hA5, 8'h00, 8'h00, 8'h00);
    tbl[18] = v(8'hFF, 8'hFF, 8'h00, 8'hA5, 8'hA7, 8'hA7, 8'hA5, 8'h00, 8'h00, 8'h00);
    tbl[19] = v(8'hFF, 8'hFF, 8'h02, 8'hA5, 8'hA7, 8'hA7, 8'hA7, 8'h00, 8'h00, 8'h02);
    tbl[20] = v(8'hFF, 8'hFF, 8'h00, 8'hA5, 8'hA7, 8'hA7, 8'hA7, 8'h00, 8'h02, 8'h02);
    tbl[21] = v(8'hFF, 8'hFF, 8'h00, 8'hA5, 8'hA7, 8'hA7, 8'hA7, 8'h00, 8'h00, 8'h02);

    rst_n = 1'b0;
    s = 8'hFF; r = 8'hFF; clr = 8'h00;
    #22;
    check_all_q("reset_q", 8'hA5);
    for (int m = 0; m < 4; m++) begin
      check("reset_rise", rise_a[m], 8'h00);
      check("reset_conf", conf_a[m], 8'h00);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(8'hFF, 8'hFF, 8'h00);
      check_all_q("idle_q", 8'hA5);
      check("idle_rise", rise_a[0], 8'h00);
    end

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].s, tbl[i].r, tbl[i].clr);
      for (int m = 0; m < 4; m++) begin
        check($sformatf("vec%0d_q_m%0d", i, m), q_a[m], tbl[i].q[m]);
        check($sformatf("vec%0d_qn_m%0d", i, m), qn_a[m], ~tbl[i].q[m]);
        check($sformatf("vec%0d_rise_m%0d", i, m), rise_a[m], (m == 3) ? tbl[i].rise3 : tbl[i].rise);
        check($sformatf("vec%0d_conf_m%0d", i, m), conf_a[m], tbl[i].conf);
      end
    end

    // Edge channel 2: clear it, then hold s[2] for 20 cycles with an r[2] pulse.
    step(8'hFF, 8'hFB, 8'h00);
    step(8'hFF, 8'hFF, 8'h00);
    step(8'hFF, 8'hFF, 8'h00);
    check("edge_clear", q_a[0] & 8'h04, 8'h00);
    step(8'hFF, 8'hFF, 8'h00);
    for (int j = 0; j < 20; j++) begin
      step(8'hFB, (j == 8) ? 8'hFB : 8'hFF, 8'h00);
      for (int m = 0; m < 4; m++) begin
        check($sformatf("edge_hold%0d_m%0d", j, m), q_a[m] & 8'h04,
              (j >= 2 && j < 10) ? 8'h04 : 8'h00);
        check($sformatf("edge_conf%0d_m%0d", j, m), conf_a[m] & 8'h04, 8'h00);
      end
    end
    step(8'hFF, 8'hFF, 8'h00);
    check("edge_gap", q_a[0] & 8'h04, 8'h00);
    step(8'hFB, 8'hFF, 8'h00);
    check("edge_rearm0", q_a[0] & 8'h04, 8'h00);
    step(8'hFB, 8'hFF, 8'h00);
    check("edge_rearm1", q_a[0] & 8'h04, 8'h00);
    step(8'hFB, 8'hFF, 8'h00);
    check("edge_rearm2", q_a[0] & 8'h04, 8'h04);
    step(8'hFF, 8'hFF, 8'h00);

    // Reset mid-flight with s[3] released before reset deasserts: no set.
    step(8'hF7, 8'hFF, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check_all_q("midrst_q", 8'hA5);
    check("midrst_conf", conf_a[0], 8'h00);
    check("midrst_rise", rise_a[0], 8'h00);
    s = 8'hFF;
    #10 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(8'hFF, 8'hFF, 8'h00);
      check("midrst_idle_q", q_a[0], 8'hA5);
      check("midrst_idle_rise", rise_a[0], 8'h00);
    end

    // Reset mid-flight with s[3] still active at release: set on 3rd edge.
    step(8'hF7, 8'hFF, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check_all_q("midrst2_q", 8'hA5);
    #10 rst_n = 1'b1;
    step(8'hF7, 8'hFF, 8'h00);
    check("rel_edge1", q_a[0], 8'hA5);
    step(8'hF7, 8'hFF, 8'h00);
    check("rel_edge2", q_a[0], 8'hA5);
    step(8'hF7, 8'hFF, 8'h00);
    check_all_q("rel_edge3", 8'hAD);
    step(8'hFF, 8'hFF, 8'h00);
    check("rel_rise", rise_a[0], 8'h08);
    step(8'hFF, 8'hFF, 8'h00);
    check("rel_rise_end", rise_a[0], 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
